// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a registered fetch port, a streaming program loader
// and a power-up clear sequencer that writes NOP_WORD into every location.
module instr_mem_ctrl #(
    parameter int                 DATA_W         = 8,
    parameter int                 ADDR_W         = 8,
    parameter int                 DEPTH          = 64,
    parameter logic [DATA_W-1:0]  NOP_WORD       = {DATA_W{1'b0}},
    parameter bit                 CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_req,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_fault,
    input  logic              prog_en,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_valid,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W:0]   prog_count,
    output logic              busy
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  clear_ptr_reg, clear_ptr_next;
    logic [CNT_W-1:0]  prog_count_reg, prog_count_next;
    logic              prog_done_reg, prog_done_next;
    logic              instr_valid_reg, instr_valid_next;
    logic              addr_fault_reg, addr_fault_next;
    logic              load_arm_reg, load_arm_next;
    logic [DATA_W-1:0] instr_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              pc_in_range;
    logic [IDX_W-1:0]  pc_idx;
    logic              fetch_en;
    logic              prog_ready_int;
    logic              prog_accept;
    logic              load_last;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    assign pc_in_range    = ({1'b0, pc} < DEPTH_C);
    assign pc_idx         = pc[IDX_W-1:0];
    assign prog_ready_int = (state_reg == ST_LOAD) && (prog_count_reg < DEPTH_C);
    assign prog_accept    = prog_ready_int && prog_valid;
    assign load_last      = prog_accept && (prog_count_reg == LAST_C);

    // Next-state and control decode.
    always_comb begin
        state_next       = state_reg;
        clear_ptr_next   = clear_ptr_reg;
        prog_count_next  = prog_count_reg;
        prog_done_next   = 1'b0;
        instr_valid_next = 1'b0;
        addr_fault_next  = 1'b0;
        load_arm_next    = load_arm_reg;
        fetch_en         = 1'b0;

        // A load that ended because memory filled up only re-arms once
        // prog_en has been released, so a held prog_en cannot restart it.
        if (!prog_en) begin
            load_arm_next = 1'b1;
        end

        case (state_reg)
            ST_CLEAR: begin
                clear_ptr_next = clear_ptr_reg + 1'b1;
                if (clear_ptr_reg == LAST_C) begin
                    state_next     = ST_RUN;
                    clear_ptr_next = '0;
                end
            end

            ST_RUN: begin
                if (prog_en && load_arm_reg) begin
                    state_next      = ST_LOAD;
                    prog_count_next = '0;
                end else if (stall) begin
                    instr_valid_next = instr_valid_reg;
                    addr_fault_next  = addr_fault_reg;
                end else if (fetch_req) begin
                    fetch_en         = 1'b1;
                    instr_valid_next = 1'b1;
                    addr_fault_next  = !pc_in_range;
                end
            end

            ST_LOAD: begin
                if (prog_accept) begin
                    prog_count_next = prog_count_reg + 1'b1;
                end
                if (!prog_en || load_last) begin
                    state_next     = ST_RUN;
                    prog_done_next = 1'b1;
                    load_arm_next  = !prog_en;
                end
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clear_ptr_reg   <= '0;
            prog_count_reg  <= '0;
            prog_done_reg   <= 1'b0;
            instr_valid_reg <= 1'b0;
            addr_fault_reg  <= 1'b0;
            load_arm_reg    <= 1'b1;
        end else begin
            state_reg       <= state_next;
            clear_ptr_reg   <= clear_ptr_next;
            prog_count_reg  <= prog_count_next;
            prog_done_reg   <= prog_done_next;
            instr_valid_reg <= instr_valid_next;
            addr_fault_reg  <= addr_fault_next;
            load_arm_reg    <= load_arm_next;
        end
    end

    // Single write port shared by the clear sequencer and the loader.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = NOP_WORD;
        if (reset) begin
            if (state_reg == ST_CLEAR) begin
                wr_en  = 1'b1;
                wr_idx = clear_ptr_reg[IDX_W-1:0];
            end else if (prog_accept) begin
                wr_en   = 1'b1;
                wr_idx  = prog_count_reg[IDX_W-1:0];
                wr_data = prog_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Registered read port; out-of-range fetches return NOP_WORD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_reg <= NOP_WORD;
        end else if (fetch_en) begin
            instr_reg <= pc_in_range ? mem[pc_idx] : NOP_WORD;
        end
    end

    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign addr_fault  = addr_fault_reg;
    assign prog_ready  = prog_ready_int;
    assign prog_done   = prog_done_reg;
    assign prog_count  = prog_count_reg;
    assign busy        = (state_reg != ST_RUN);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: clear, load, fetch, fault, stall,
// full load and reset during load, on two differently sized instances.
module tb_instr_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH 64, clear on reset, NOP 8'h13
    logic       a_reset, a_fetch_req, a_stall, a_prog_en, a_prog_valid;
    logic [7:0] a_pc, a_prog_data, a_instr;
    logic       a_instr_valid, a_addr_fault, a_prog_ready, a_prog_done, a_busy;
    logic [8:0] a_prog_count;

    // Instance B: DEPTH 8, no clear, NOP 8'hEE
    logic       b_reset, b_fetch_req, b_stall, b_prog_en, b_prog_valid;
    logic [7:0] b_pc, b_prog_data, b_instr;
    logic       b_instr_valid, b_addr_fault, b_prog_ready, b_prog_done, b_busy;
    logic [8:0] b_prog_count;

    int checks_cnt = 0;
    int errors_cnt = 0;

    instr_mem_ctrl #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(64), .NOP_WORD(8'h13), .CLEAR_ON_RESET(1'b1)
    ) u_dut_a (
        .clk(clk), .reset(a_reset), .pc(a_pc), .fetch_req(a_fetch_req), .stall(a_stall),
        .instr(a_instr), .instr_valid(a_instr_valid), .addr_fault(a_addr_fault),
        .prog_en(a_prog_en), .prog_data(a_prog_data), .prog_valid(a_prog_valid),
        .prog_ready(a_prog_ready), .prog_done(a_prog_done), .prog_count(a_prog_count),
        .busy(a_busy)
    );

    instr_mem_ctrl #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(8), .NOP_WORD(8'hEE), .CLEAR_ON_RESET(1'b0)
    ) u_dut_b (
        .clk(clk), .reset(b_reset), .pc(b_pc), .fetch_req(b_fetch_req), .stall(b_stall),
        .instr(b_instr), .instr_valid(b_instr_valid), .addr_fault(b_addr_fault),
        .prog_en(b_prog_en), .prog_data(b_prog_data), .prog_valid(b_prog_valid),
        .prog_ready(b_prog_ready), .prog_done(b_prog_done), .prog_count(b_prog_count),
        .busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input bit sel_b, input logic [7:0] p, input logic [7:0] exp_i,
                         input logic exp_f, input string tag);
        logic [7:0] got_i;
        logic       got_v, got_f;
        if (sel_b) begin
            b_pc = p; b_fetch_req = 1'b1;
        end else begin
            a_pc = p; a_fetch_req = 1'b1;
        end
        tick();
        got_i = sel_b ? b_instr : a_instr;
        got_v = sel_b ? b_instr_valid : a_instr_valid;
        got_f = sel_b ? b_addr_fault : a_addr_fault;
        $display("fetch %s pc=%0d instr=%02h valid=%0b fault=%0b", tag, p, got_i, got_v, got_f);
        check_eq({tag, "_instr"}, 32'(got_i), 32'(exp_i));
        check_eq({tag, "_valid"}, 32'(got_v), 32'd1);
        check_eq({tag, "_fault"}, 32'(got_f), 32'(exp_f));
        if (sel_b) b_fetch_req = 1'b0;
        else       a_fetch_req = 1'b0;
    endtask

    initial begin
        int n;
        a_reset = 1'b0; a_pc = '0; a_fetch_req = 1'b0; a_stall = 1'b0;
        a_prog_en = 1'b0; a_prog_data = '0; a_prog_valid = 1'b0;
        b_reset = 1'b0; b_pc = '0; b_fetch_req = 1'b0; b_stall = 1'b0;
        b_prog_en = 1'b0; b_prog_data = '0; b_prog_valid = 1'b0;

        // Reset held for two edges
        tick();
        tick();
        $display("reset a: instr=%02h valid=%0b busy=%0b", a_instr, a_instr_valid, a_busy);
        check_eq("rst_a_instr", 32'(a_instr), 32'h13);
        check_eq("rst_a_valid", 32'(a_instr_valid), 32'd0);
        check_eq("rst_a_fault", 32'(a_addr_fault), 32'd0);
        check_eq("rst_a_ready", 32'(a_prog_ready), 32'd0);
        check_eq("rst_a_done", 32'(a_prog_done), 32'd0);
        check_eq("rst_a_count", 32'(a_prog_count), 32'd0);
        check_eq("rst_a_busy", 32'(a_busy), 32'd1);
        check_eq("rst_b_busy", 32'(b_busy), 32'd0);
        check_eq("rst_b_instr", 32'(b_instr), 32'hEE);
        a_reset = 1'b1;
        b_reset = 1'b1;

        // Clear takes exactly DEPTH cycles
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (!a_busy) break;
            n++;
            tick();
        end
        $display("clear a: busy cycles=%0d", n);
        check_eq("clear_busy_cycles", 32'(n), 32'd64);

        for (int i = 0; i < 64; i++) begin
            fetch(1'b0, 8'(i), 8'h13, 1'b0, $sformatf("clr%0d", i));
        end

        // Load six words, prog_en dropped with the last one
        a_prog_en = 1'b1;
        tick();
        check_eq("load_enter_ready", 32'(a_prog_ready), 32'd1);
        check_eq("load_enter_busy", 32'(a_busy), 32'd1);
        for (int k = 0; k < 6; k++) begin
            a_prog_valid = 1'b1;
            a_prog_data  = 8'(8'hA0 + k);
            if (k == 5) a_prog_en = 1'b0;
            tick();
            $display("load a: word=%02h count=%0d done=%0b", a_prog_data, a_prog_count, a_prog_done);
            check_eq($sformatf("load_a_done%0d", k), 32'(a_prog_done), (k == 5) ? 32'd1 : 32'd0);
            check_eq($sformatf("load_a_count%0d", k), 32'(a_prog_count), 32'(k + 1));
        end
        a_prog_valid = 1'b0;
        check_eq("load_a_busy_after", 32'(a_busy), 32'd0);
        tick();
        check_eq("load_a_done_once", 32'(a_prog_done), 32'd0);
        check_eq("load_a_count_hold", 32'(a_prog_count), 32'd6);

        fetch(1'b0, 8'd5, 8'hA5, 1'b0, "ld5");
        fetch(1'b0, 8'd6, 8'h13, 1'b0, "unld6");

        // Out-of-range fetches
        fetch(1'b0, 8'd64, 8'h13, 1'b1, "oor64");
        fetch(1'b0, 8'hFF, 8'h13, 1'b1, "oorFF");
        fetch(1'b0, 8'd0, 8'hA0, 1'b0, "after_oor");
        tick();
        check_eq("idle_valid", 32'(a_instr_valid), 32'd0);
        check_eq("idle_fault", 32'(a_addr_fault), 32'd0);
        check_eq("idle_instr_hold", 32'(a_instr), 32'hA0);

        // Stall holds the result while pc moves
        fetch(1'b0, 8'd2, 8'hA2, 1'b0, "pre_stall");
        a_fetch_req = 1'b1;
        a_pc = 8'd4;
        a_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            $display("stall a: cycle=%0d instr=%02h valid=%0b", s, a_instr, a_instr_valid);
            check_eq($sformatf("stall_instr%0d", s), 32'(a_instr), 32'hA2);
            check_eq($sformatf("stall_valid%0d", s), 32'(a_instr_valid), 32'd1);
        end
        a_stall = 1'b0;
        tick();
        check_eq("unstall_instr", 32'(a_instr), 32'hA4);
        check_eq("unstall_valid", 32'(a_instr_valid), 32'd1);

        // prog_en wins over a same-cycle fetch; empty load exits with count 0
        a_prog_en = 1'b1;
        tick();
        check_eq("prio_valid", 32'(a_instr_valid), 32'd0);
        check_eq("prio_busy", 32'(a_busy), 32'd1);
        a_fetch_req = 1'b0;
        a_prog_en = 1'b0;
        tick();
        check_eq("empty_load_done", 32'(a_prog_done), 32'd1);
        check_eq("empty_load_count", 32'(a_prog_count), 32'd0);

        // Full load on the 8-deep instance with prog_en held
        b_prog_en = 1'b1;
        tick();
        check_eq("full_enter_ready", 32'(b_prog_ready), 32'd1);
        for (int k = 0; k < 10; k++) begin
            b_prog_valid = 1'b1;
            b_prog_data  = 8'(8'h50 + k);
            tick();
            $display("load b: word=%02h count=%0d ready=%0b done=%0b busy=%0b",
                     b_prog_data, b_prog_count, b_prog_ready, b_prog_done, b_busy);
            check_eq($sformatf("full_done%0d", k), 32'(b_prog_done), (k == 7) ? 32'd1 : 32'd0);
            check_eq($sformatf("full_count%0d", k), 32'(b_prog_count), (k < 7) ? 32'(k + 1) : 32'd8);
            check_eq($sformatf("full_ready%0d", k), 32'(b_prog_ready), (k < 7) ? 32'd1 : 32'd0);
            check_eq($sformatf("full_busy%0d", k), 32'(b_busy), (k < 7) ? 32'd1 : 32'd0);
        end
        b_prog_en = 1'b0;
        b_prog_valid = 1'b0;
        tick();
        check_eq("full_after_busy", 32'(b_busy), 32'd0);
        check_eq("full_after_count", 32'(b_prog_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            fetch(1'b1, 8'(i), 8'(8'h50 + i), 1'b0, $sformatf("full%0d", i));
        end
        fetch(1'b1, 8'd8, 8'hEE, 1'b1, "b_oor8");

        // Reset during a load
        b_prog_en = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            b_prog_valid = 1'b1;
            b_prog_data  = 8'(8'h70 + k);
            tick();
            $display("load b: word=%02h count=%0d", b_prog_data, b_prog_count);
        end
        b_prog_data = 8'h73;
        b_reset = 1'b0;
        tick();
        $display("reset b mid-load: busy=%0b count=%0d done=%0b", b_busy, b_prog_count, b_prog_done);
        check_eq("midrst_busy", 32'(b_busy), 32'd0);
        check_eq("midrst_count", 32'(b_prog_count), 32'd0);
        check_eq("midrst_done", 32'(b_prog_done), 32'd0);
        check_eq("midrst_ready", 32'(b_prog_ready), 32'd0);
        b_reset = 1'b1;
        b_prog_en = 1'b0;
        b_prog_valid = 1'b0;
        tick();
        check_eq("midrst_done_after", 32'(b_prog_done), 32'd0);
        check_eq("midrst_busy_after", 32'(b_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            fetch(1'b1, 8'(i), 8'(8'h70 + i), 1'b0, $sformatf("midrst%0d", i));
        end
        fetch(1'b1, 8'd3, 8'h53, 1'b0, "midrst_keep3");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised instruction memory with registered fetch port, sequential program loader and power-up clear sequencer.
- Sits between the PC register and the decoder of the single-cycle/multi-cycle cores.
- Replaces fixed-size, combinational-read, file-only instruction storage with a run-time loadable, bounds-checked store.
- Programs can be streamed in after reset without re-elaboration.

Parameters:
- DATA_W, 8, instruction word width in bits.
- ADDR_W, 8, PC/address width.
- DEPTH, 64, number of words; must satisfy DEPTH <= 2**ADDR_W.
- NOP_WORD, 8'h00, value written by clear and returned on faulted fetch; DATA_W bits.
- CLEAR_ON_RESET, 1, 1 = run CLEAR sequence after reset; 0 = go straight to RUN, contents retained.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-low reset.
- pc  input  ADDR_W  fetch address, word-addressed.
- fetch_req  input  1  request fetch of mem[pc].
- stall  input  1  hold current instr/instr_valid.
- instr  output  DATA_W  fetched instruction word.
- instr_valid  output  1  instr holds a fetch result.
- addr_fault  output  1  fetched pc was >= DEPTH; qualifies instr.
- prog_en  input  1  enter/remain in load mode.
- prog_data  input  DATA_W  word to load.
- prog_valid  input  1  prog_data valid.
- prog_ready  output  1  loader accepts a word this cycle.
- prog_done  output  1  one-cycle pulse at end of load.
- prog_count  output  ADDR_W+1  words written in current/last load.
- busy  output  1  high in CLEAR or LOAD.

Behaviour:
- Reset (reset==0 at posedge clk): state = CLEAR if CLEAR_ON_RESET else RUN; clear_ptr = 0.
  - Outputs: instr = NOP_WORD, instr_valid = 0, addr_fault = 0, prog_ready = 0, prog_done = 0, prog_count = 0.
  - busy = CLEAR_ON_RESET.
  - Reset in any state, including mid-LOAD or mid-CLEAR, aborts immediately. No partial-state carry-over; memory words already written stay written.
- CLEAR: one word per cycle, mem[clear_ptr] <= NOP_WORD, clear_ptr increments.
  - After writing DEPTH-1, go to RUN; takes exactly DEPTH cycles.
  - prog_en and fetch_req are ignored. busy = 1, instr_valid = 0.
- RUN:
  - prog_en = 1: next state LOAD, prog_count <= 0, write pointer <= 0, instr_valid <= 0. prog_en has priority over a same-cycle fetch_req, which is dropped.
  - Else if stall = 1: instr, instr_valid and addr_fault hold.
  - Else if fetch_req = 1: one-cycle latency. Next edge gives instr_valid <= 1.
    - pc < DEPTH: instr <= mem[pc], addr_fault <= 0.
    - pc >= DEPTH: instr <= NOP_WORD, addr_fault <= 1.
  - Else: instr_valid <= 0, addr_fault <= 0, instr holds.
  - Read is registered; no combinational path from pc to instr.
- LOAD:
  - prog_ready = 1 while prog_count < DEPTH. busy = 1, instr_valid = 0.
  - prog_valid & prog_ready: mem[prog_count] <= prog_data, prog_count += 1.
  - Exit to RUN when prog_en falls, or on the cycle prog_count reaches DEPTH (full). prog_done pulses high for exactly one cycle on the transition.
  - Full: a word offered on the cycle count reaches DEPTH is the last accepted. Further prog_valid is ignored until a new LOAD.
  - prog_en falling with prog_valid high in the same cycle: that word is written, then exit.
  - prog_count holds its final value in RUN until next LOAD or reset.
  - Unloaded locations keep prior contents (no implicit clear).
- Memory: DEPTH x DATA_W register array.
  - One write port, muxed between CLEAR and LOAD, which are mutually exclusive.
  - One synchronous read port.
- Widths: prog_count is ADDR_W+1 so the value DEPTH is representable when DEPTH = 2**ADDR_W.

Test Plan:
- Reset then clear: DEPTH=64, CLEAR_ON_RESET=1, NOP_WORD=8'h13, reset low 2 cycles then high.
  - busy high exactly 64 cycles.
  - fetch pc=0..63 -> instr=8'h13, addr_fault=0.
- Load and fetch: prog_en=1, stream 8'hA0..8'hA5 with prog_valid each cycle, drop prog_en with last word.
  - prog_done pulses once; prog_count=6.
  - fetch pc=5 -> instr=8'hA5 one cycle after request, instr_valid=1.
- Out of range: DEPTH=64, fetch pc=8'd64 and pc=8'hFF -> instr=NOP_WORD, addr_fault=1, instr_valid=1. Next fetch pc=0 -> addr_fault=0.
- Stall: fetch pc=2 (8'hA2), assert stall 3 cycles while pc changes to 4 -> instr stays 8'hA2, valid stays 1. Release -> instr=8'hA4 next cycle.
- Full load: DEPTH=8, stream 10 words with prog_en held high.
  - Only first 8 written; prog_ready falls; prog_done pulses at 8th write; prog_count=8.
  - Returns to RUN despite prog_en high.
- Reset mid-load: reset after 3 words of a load, CLEAR_ON_RESET=0 -> state RUN, prog_count=0, prog_done never pulses, words 0..2 readable with new values.
